// File: rtl/ex_stage_pkg.sv
// Shared constants for the execute stage: widths, ALU opcodes and divider FSM states.
package ex_stage_pkg;
  localparam int EX_DW = 16;
  localparam int EX_RW = 8;

  localparam logic [3:0] OP_ADD   = 4'd0;
  localparam logic [3:0] OP_SUB   = 4'd1;
  localparam logic [3:0] OP_AND   = 4'd2;
  localparam logic [3:0] OP_OR    = 4'd3;
  localparam logic [3:0] OP_XOR   = 4'd4;
  localparam logic [3:0] OP_NOT   = 4'd5;
  localparam logic [3:0] OP_SHL   = 4'd6;
  localparam logic [3:0] OP_SHR   = 4'd7;
  localparam logic [3:0] OP_SRA   = 4'd8;
  localparam logic [3:0] OP_SLT   = 4'd9;
  localparam logic [3:0] OP_SLTU  = 4'd10;
  localparam logic [3:0] OP_MUL   = 4'd11;
  localparam logic [3:0] OP_PASSB = 4'd12;
  localparam logic [3:0] OP_PASSA = 4'd13;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } div_state_e;
endpackage

// File: rtl/ex_divider.sv
// Iterative unsigned restoring divider, one quotient bit per cycle.
// start_i is taken in IDLE; done_o is held until hold_i drops, then the FSM returns to IDLE.
module ex_divider import ex_stage_pkg::*; #(
  parameter int DW         = EX_DW,
  parameter int DIV_CYCLES = EX_DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          hold_i,
  input  logic          start_i,
  input  logic [DW-1:0] dividend_i,
  input  logic [DW-1:0] divisor_i,
  output logic          busy_o,
  output logic          done_o,
  output logic [DW-1:0] quotient_o,
  output logic [DW-1:0] remainder_o
);
  localparam int CW = $clog2(DIV_CYCLES + 1);

  div_state_e    state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic [DW-1:0] quo_q, quo_d, rem_q, rem_d, dvs_q, dvs_d;
  logic          dz_q, dz_d;
  logic [DW:0]   rem_sh, diff;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dvs_d   = dvs_q;
    dz_d    = dz_q;
    // quo_q doubles as the dividend shift register: its MSB feeds the partial remainder
    rem_sh  = {rem_q, quo_q[DW-1]};
    diff    = rem_sh - {1'b0, dvs_q};
    if (!hold_i) begin
      unique case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            state_d = ST_RUN;
            count_d = '0;
            quo_d   = dividend_i;
            rem_d   = '0;
            dvs_d   = divisor_i;
            dz_d    = (divisor_i == '0);
          end
        end
        ST_RUN: begin
          if (!diff[DW]) begin
            rem_d = diff[DW-1:0];
            quo_d = {quo_q[DW-2:0], 1'b1};
          end else begin
            rem_d = rem_sh[DW-1:0];
            quo_d = {quo_q[DW-2:0], 1'b0};
          end
          count_d = count_q + 1'b1;
          if (count_q == CW'(DIV_CYCLES - 1)) state_d = ST_DONE;
        end
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      dvs_q   <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dvs_q   <= dvs_d;
      dz_q    <= dz_d;
    end
  end

  assign busy_o      = (state_q == ST_RUN);
  assign done_o      = (state_q == ST_DONE);
  // A zero divisor already yields remainder = dividend; the quotient is forced explicitly
  assign quotient_o  = dz_q ? '1 : quo_q;
  assign remainder_o = rem_q;
endmodule

// File: rtl/ex_stage.sv
// Execute stage: ALU, branch/jump resolution, iterative divide and the EX/MEM register.
// Optional operand forwarding from the EX/MEM register is enabled by defining EX_FORWARDING_EN.
module ex_stage import ex_stage_pkg::*; #(
  parameter int DW         = EX_DW,
  parameter int RW         = EX_RW,
  parameter int DIV_CYCLES = EX_DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          hold_i,
  input  logic [3:0]    op_i,
  input  logic          j_i,
  input  logic          b_i,
  input  logic          mem_i,
  input  logic          store_i,
  input  logic          mwe_i,
  input  logic          mux_i,
  input  logic          rwe_i,
  input  logic          div_i,
  input  logic          im_i,
  input  logic [DW-1:0] data_a_i,
  input  logic [DW-1:0] data_b_i,
  input  logic [RW-1:0] a_reg_i,
  input  logic [RW-1:0] b_reg_i,
  input  logic [RW-1:0] c_reg_i,
  output logic          stall_o,
  output logic [DW-1:0] result_o,
  output logic [DW-1:0] store_data_o,
  output logic [RW-1:0] c_reg_o,
  output logic          mem_o,
  output logic          store_o,
  output logic          mwe_o,
  output logic          mux_o,
  output logic          rwe_o,
  output logic          br_taken_o,
  output logic [DW-1:0] br_target_o
);
  logic [DW-1:0] result_q, result_d, store_data_q, store_data_d, br_target_q, br_target_d;
  logic [RW-1:0] c_reg_q, c_reg_d;
  logic mem_q, mem_d, store_q, store_d, mwe_q, mwe_d, mux_q, mux_d, rwe_q, rwe_d;
  logic br_taken_q, br_taken_d;

  logic [DW-1:0] imm, op_a, op_b, alu_res, quo, rem, br_target;
  logic signed [DW-1:0] a_s, b_s;
  logic [3:0] sh;
  logic div_busy, div_done, issue, br_taken;

  assign imm = {{(DW-RW){1'b0}}, b_reg_i};

`ifdef EX_FORWARDING_EN
  logic fwd_a, fwd_b;
  assign fwd_a = rwe_q && (c_reg_q != '0) && (c_reg_q == a_reg_i);
  assign fwd_b = !im_i && rwe_q && (c_reg_q != '0) && (c_reg_q == b_reg_i);
  assign op_a  = fwd_a ? result_q : data_a_i;
  assign op_b  = im_i ? imm : (fwd_b ? result_q : data_b_i);
`else
  logic unused_a_reg;
  assign unused_a_reg = ^a_reg_i;
  assign op_a = data_a_i;
  assign op_b = im_i ? imm : data_b_i;
`endif

  assign a_s = op_a;
  assign b_s = op_b;
  assign sh  = op_b[3:0];

  always_comb begin
    alu_res = op_a;
    unique case (op_i)
      OP_ADD:   alu_res = op_a + op_b;
      OP_SUB:   alu_res = op_a - op_b;
      OP_AND:   alu_res = op_a & op_b;
      OP_OR:    alu_res = op_a | op_b;
      OP_XOR:   alu_res = op_a ^ op_b;
      OP_NOT:   alu_res = ~op_a;
      OP_SHL:   alu_res = op_a << sh;
      OP_SHR:   alu_res = op_a >> sh;
      OP_SRA:   alu_res = a_s >>> sh;
      OP_SLT:   alu_res = {{(DW-1){1'b0}}, (a_s < b_s)};
      OP_SLTU:  alu_res = {{(DW-1){1'b0}}, (op_a < op_b)};
      OP_MUL:   alu_res = op_a * op_b;
      OP_PASSB: alu_res = op_b;
      default:  alu_res = op_a;
    endcase
  end

  assign br_taken  = j_i || (b_i && (data_a_i == '0));
  assign br_target = j_i ? data_a_i : (br_taken ? data_b_i : '0);

  // A divide still presented while the FSM sits in DONE is the one being retired, not a new issue
  assign issue   = !rst && !hold_i && div_i && !div_busy && !div_done;
  assign stall_o = !rst && (hold_i || issue || div_busy);

  ex_divider #(.DW(DW), .DIV_CYCLES(DIV_CYCLES)) u_div (
    .clk         (clk),
    .rst         (rst),
    .hold_i      (hold_i),
    .start_i     (issue),
    .dividend_i  (op_a),
    .divisor_i   (op_b),
    .busy_o      (div_busy),
    .done_o      (div_done),
    .quotient_o  (quo),
    .remainder_o (rem)
  );

  always_comb begin
    result_d     = result_q;
    store_data_d = store_data_q;
    c_reg_d      = c_reg_q;
    mem_d        = mem_q;
    store_d      = store_q;
    mwe_d        = mwe_q;
    mux_d        = mux_q;
    rwe_d        = rwe_q;
    br_taken_d   = br_taken_q;
    br_target_d  = br_target_q;
    if (!hold_i) begin
      if (issue || div_busy) begin
        rwe_d = 1'b0;
        mwe_d = 1'b0;
      end else begin
        result_d     = div_done ? (op_i[0] ? rem : quo) : alu_res;
        store_data_d = data_b_i;
        c_reg_d      = c_reg_i;
        mem_d        = mem_i;
        store_d      = store_i;
        mwe_d        = mwe_i;
        mux_d        = mux_i;
        rwe_d        = rwe_i;
        br_taken_d   = br_taken;
        br_target_d  = br_target;
      end
    end
  end

  // EX/MEM register boundary
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result_q     <= '0;
      store_data_q <= '0;
      c_reg_q      <= '0;
      mem_q        <= 1'b0;
      store_q      <= 1'b0;
      mwe_q        <= 1'b0;
      mux_q        <= 1'b0;
      rwe_q        <= 1'b0;
      br_taken_q   <= 1'b0;
      br_target_q  <= '0;
    end else begin
      result_q     <= result_d;
      store_data_q <= store_data_d;
      c_reg_q      <= c_reg_d;
      mem_q        <= mem_d;
      store_q      <= store_d;
      mwe_q        <= mwe_d;
      mux_q        <= mux_d;
      rwe_q        <= rwe_d;
      br_taken_q   <= br_taken_d;
      br_target_q  <= br_target_d;
    end
  end

  assign result_o     = result_q;
  assign store_data_o = store_data_q;
  assign c_reg_o      = c_reg_q;
  assign mem_o        = mem_q;
  assign store_o      = store_q;
  assign mwe_o        = mwe_q;
  assign mux_o        = mux_q;
  assign rwe_o        = rwe_q;
  assign br_taken_o   = br_taken_q;
  assign br_target_o  = br_target_q;
endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage of the 16-bit pipeline. Sits directly downstream of the decode-to-execute pipeline register.
- Consumes that register's control bits, operands and register indices.
- Computes ALU, multi-cycle divide and branch/jump results into a registered EX/MEM output.
- Drives stall_o back to the decode-to-execute register while a divide is in flight or downstream holds.

Parameters:
- DW, 16, datapath width.
- RW, 8, register-index width.
- DIV_CYCLES, 16, divider iterations; must equal DW.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous reset, active-high
- hold_i  in  1  downstream (memory) stall; freezes this stage
- op_i  in  4  ALU opcode
- j_i, b_i  in  1 each  jump, branch
- mem_i, store_i, mwe_i, mux_i, rwe_i  in  1 each  pass-through controls
- div_i  in  1  divide instruction
- im_i  in  1  operand B = {8'h00, b_reg_i}
- data_a_i, data_b_i  in  DW each  operands
- a_reg_i, b_reg_i, c_reg_i  in  RW each  source/destination indices
- stall_o  out  1  freeze upstream register
- result_o  out  DW  registered ALU/divide result
- store_data_o  out  DW  registered data_b_i
- c_reg_o  out  RW  registered destination
- mem_o, store_o, mwe_o, mux_o, rwe_o  out  1 each  registered controls
- br_taken_o  out  1  registered branch/jump taken
- br_target_o  out  DW  registered target

Behaviour:
- Reset (async, rst=1): every output register cleared to 0; FSM to IDLE; divider registers 0; stall_o=0.
- ALU ops: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOT A, 6 SHL A by B[3:0], 7 SHR, 8 SRA, 9 SLT signed (result 1/0), 10 SLTU, 11 MUL low 16 bits, 12 PASS B, 13-15 PASS A.
- All arithmetic is modulo 2^16; carries are discarded.
- Non-divide latency: 1 cycle. Inputs sampled at edge N appear on outputs after edge N.
- Branch: taken when b_i=1 and data_a_i==0; target = data_b_i.
- Jump: j_i=1 always taken; target = data_a_i.
- Otherwise br_taken_o=0 and br_target_o=0.
- Divider FSM states: IDLE, RUN, DONE.
  - IDLE with div_i=1: stall_o=1 combinationally; latch operands; count=0; go RUN.
  - RUN: one restoring-division step per cycle; stall_o=1; after DIV_CYCLES steps go DONE.
  - DONE: stall_o=hold_i. If hold_i=0, the output register captures the result and the FSM returns to IDLE. If hold_i=1, it stays in DONE.
- stall_o is high exactly 17 cycles per divide (issue cycle + 16 RUN).
- The held divide instruction still present at the inputs in DONE is not re-issued.
- Divide result: op_i[0]=0 gives the quotient, 1 gives the remainder; unsigned.
- Divide by zero: quotient 0xFFFF, remainder = dividend, same latency.
- While the FSM is not IDLE/DONE, output controls are not updated; rwe_o=0 and mwe_o=0 are written as a bubble.
- hold_i=1: output register frozen, FSM frozen, stall_o=1.
- Simultaneous hold_i and div issue: issue deferred until hold_i=0.
- Reset mid-divide: divide aborted, no result written.

Optional Feature:
- Macro EX_FORWARDING_EN.
- Defined: if rwe_o=1 and c_reg_o!=0 and c_reg_o==a_reg_i, operand A uses result_o instead of data_a_i. Same rule for B when im_i=0 (b_reg_i compare).
- Undefined: operands are always data_a_i/data_b_i; the compare logic is absent.

Decomposition:
- Shared package: ALU opcode constants (OP_ADD..OP_PASSA), DW/RW constants, FSM state encodings.
- One sub-module, ex_divider: iterative restoring divider with start/busy/done handshake and div-by-zero handling. ex_stage instantiates it and owns the ALU, branch logic and output register.

Test Plan:
- op=ADD, A=0x1234, B=0x0001 -> result_o=0x1235 one edge later, stall_o=0 throughout.
- div_i=1, op=0, A=100, B=7 -> stall_o high 17 cycles, then result_o=0x000E; repeat with op=1 -> result_o=0x0002.
- div_i=1, A=0x0055, B=0 -> quotient 0xFFFF, remainder 0x0055, identical stall length.
- rst pulsed on the 8th RUN cycle -> all outputs 0 immediately, stall_o=0, next ADD completes in 1 cycle.
- hold_i=1 for 3 cycles during ADD stream -> outputs unchanged, stall_o=1 during those cycles; divide reaching DONE under hold waits, then writes once.
- EX_FORWARDING_EN: ADD to r5 (0x0010+0x0001), then SUB with a_reg=5, stale data_a_i=0 and B=1 -> result_o=0x0010. Without the macro -> 0xFFFF.
